gate_bist_ctrl: RTL and testbench
=================================

GATE_BIST_CTRL -- requirements
Module: gate_bist_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, named clk and rst.
REQ-002 The block SHALL have parameter N_IN, default 2, giving the number of DUT gate inputs (1..4).
REQ-003 The block SHALL have parameter EXP, default 4'b0111 (NAND), width 2^N_IN, where EXP[p] is the expected DUT output for pattern p.
REQ-004 The block SHALL have parameter SETTLE, default 1, giving the settle cycles per pattern (1..15).
REQ-005 The ports SHALL be, one per line:
  clk  in  1  rising-edge clock
  rst  in  1  asynchronous active-high reset
  start  in  1  run request, sampled in IDLE or DONE
  pat_out  out  N_IN  DUT input vector; pat_out[N_IN-1] is input a, pat_out[0] is input b
  dut_res  in  1  DUT output (for a 2-input gate, res)
  busy  out  1  high in APPLY or SAMPLE
  done  out  1  high in DONE
  pass  out  1  high in DONE only when err_cnt==0
  err_cnt  out  N_IN+1  mismatch count for the current run
  fail_idx  out  N_IN  pattern index of the first mismatch; 0 if none
  signature  out  2^N_IN  collected DUT responses (see Configuration)

Function
REQ-006 The FSM SHALL have four states: IDLE, APPLY, SAMPLE and DONE; all outputs SHALL be registered.
REQ-007 IDLE or DONE with start=1 SHALL move the FSM to APPLY on that edge, with pattern=0, settle count=0, err_cnt=0, fail_idx=0 and signature=0.
REQ-008 APPLY SHALL drive pat_out=pattern and increment the settle count; when the count reaches SETTLE-1, the FSM SHALL move to SAMPLE.
REQ-009 SAMPLE SHALL hold pat_out, compare dut_res with EXP[pattern], and on a mismatch increment err_cnt; on the first mismatch it SHALL also load fail_idx=pattern.
REQ-010 SAMPLE SHALL return to APPLY with pattern+1 and settle count 0, or move to DONE when pattern==2^N_IN-1; pattern SHALL NOT wrap during a run.
REQ-011 DONE SHALL hold err_cnt, fail_idx, signature and pat_out until the next start.
REQ-012 done SHALL rise exactly 2^N_IN*(SETTLE+1) rising edges after the edge that samples start.
REQ-013 start in APPLY or SAMPLE SHALL be ignored, with no restart and no effect on any counter.
REQ-014 err_cnt SHALL NOT saturate, because its width holds the full range 0..2^N_IN.

Reset
REQ-015 rst=1 SHALL immediately force: state=IDLE, pat_out=0, busy=0, done=0, pass=0, err_cnt=0, fail_idx=0, signature=0, and settle count=0.
REQ-016 Reset asserted mid-run SHALL abort the run; after release, the block SHALL wait in IDLE for start.

Configuration
REQ-017 With macro GATE_BIST_SIG_EN defined, each SAMPLE SHALL update signature to {signature[2^N_IN-2:0], dut_res}, so that pattern 0 ends in the MSB.
REQ-018 Without GATE_BIST_SIG_EN, signature SHALL be constant 0 and its register SHALL NOT be synthesised; all other behaviour SHALL be unchanged.

Verification
REQ-019 Defaults, correct NAND DUT, one start pulse -> pat_out sequence 00,01,10,11; done after 8 edges; pass=1; err_cnt=0; signature=4'b1110 (with macro) or 0 (without).
REQ-020 DUT stuck-at-0 -> err_cnt=3, fail_idx=0, pass=0, signature=4'b0000.
REQ-021 DUT replaced by AND (responses 0,0,0,1) -> err_cnt=4, fail_idx=0, pass=0, signature=4'b0001.
REQ-022 SETTLE=3, correct NAND DUT -> done after 16 edges; each pat_out value held 4 cycles; pass=1.
REQ-023 start pulsed while busy, then rst asserted during pattern 2 -> start ignored; all outputs 0 immediately; a following start runs a clean pass.
REQ-024 start held high in DONE -> a new run begins; err_cnt and signature clear on that edge; a second identical result is produced.

Source files
------------

// File: rtl/gate_bist_ctrl.sv
// Built-in self-test sequencer for a small combinational gate: walks every input
// pattern, checks each response against EXP. Define GATE_BIST_SIG_EN to collect a response signature.
module gate_bist_ctrl #(
  parameter int                   N_IN   = 2,
  parameter logic [(1<<N_IN)-1:0] EXP    = 4'b0111,
  parameter int                   SETTLE = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic [N_IN-1:0]        pat_out,
  input  logic                   dut_res,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [N_IN:0]          err_cnt,
  output logic [N_IN-1:0]        fail_idx,
  output logic [(1<<N_IN)-1:0]   signature
);

  localparam int              N_PAT       = 1 << N_IN;
  localparam logic [N_IN-1:0] LAST_PAT    = N_IN'(N_PAT - 1);
  localparam logic [3:0]      SETTLE_LAST = 4'(SETTLE - 1);

  typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, DONE} state_t;

  state_t          state_q, state_d;
  logic [3:0]      settle_q, settle_d;
  logic [N_IN-1:0] pat_d;
  logic [N_IN:0]   err_d;
  logic [N_IN-1:0] fail_d;
  logic            busy_d, done_d, pass_d;

  logic launch, mismatch, last_pat, settle_end;

  // pat_out doubles as the pattern counter: it always equals the pattern under test.
  assign launch     = start && (state_q == IDLE || state_q == DONE);
  assign mismatch   = (dut_res != EXP[pat_out]);
  assign last_pat   = (pat_out == LAST_PAT);
  assign settle_end = (settle_q == SETTLE_LAST);

  // NOTE: state and every output use non-blocking assignments so all registers
  // update together from values sampled before the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      settle_q <= '0;
      pat_out  <= '0;
      err_cnt  <= '0;
      fail_idx <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      pat_out  <= pat_d;
      err_cnt  <= err_d;
      fail_idx <= fail_d;
      busy     <= busy_d;
      done     <= done_d;
      pass     <= pass_d;
    end
  end

  // NOTE: every combinational output gets a default first, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: if (start) state_d = APPLY;
      APPLY:      if (settle_end) state_d = SAMPLE;
      SAMPLE:     state_d = last_pat ? DONE : APPLY;
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    pat_d    = pat_out;
    settle_d = settle_q;
    err_d    = err_cnt;
    fail_d   = fail_idx;
    if (launch) begin
      pat_d    = '0;
      settle_d = '0;
      err_d    = '0;
      fail_d   = '0;
    end else if (state_q == APPLY) begin
      settle_d = settle_q + 4'd1;
    end else if (state_q == SAMPLE) begin
      settle_d = '0;
      if (mismatch) begin
        err_d = err_cnt + 1'b1;
        // Only the first mismatch of a run records its pattern index.
        if (err_cnt == '0) fail_d = pat_out;
      end
      if (!last_pat) pat_d = pat_out + 1'b1;
    end
    busy_d = (state_d == APPLY) || (state_d == SAMPLE);
    done_d = (state_d == DONE);
    pass_d = (state_d == DONE) && (err_d == '0);
  end

`ifdef GATE_BIST_SIG_EN
  logic [N_PAT-1:0] sig_q, sig_d;

  // Responses shift in from the LSB, so pattern 0 finishes in the MSB.
  always_comb begin
    sig_d = sig_q;
    if (launch)                  sig_d = '0;
    else if (state_q == SAMPLE)  sig_d = {sig_q[N_PAT-2:0], dut_res};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sig_q <= '0;
    else     sig_q <= sig_d;
  end

  assign signature = sig_q;
`else
  assign signature = '0;
`endif

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// Scoreboard bench for gate_bist_ctrl: default instance (SETTLE=1) with a selectable
// fake DUT gate, plus a SETTLE=3 instance driving a correct NAND.
module tb_gate_bist_ctrl;

  typedef struct {
    int err;
    int fail;
    int pass;
    int sig;
    int lat;
    int start_cyc;
  } exp_t;

  logic       clk, rst;
  logic       start0, start3;
  logic [1:0] pat0, pat3;
  logic       res0, res3;
  logic       busy0, done0, pass0, busy3, done3, pass3;
  logic [2:0] err0, err3;
  logic [1:0] fail0, fail3;
  logic [3:0] sig0, sig3;
  int         mode;
  int         cyc;
  int         checks, failures;
  exp_t       sb0[$], sb3[$];
  logic       done0_prev, done3_prev;

  gate_bist_ctrl u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .pat_out(pat0), .dut_res(res0),
    .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err0),
    .fail_idx(fail0), .signature(sig0)
  );

  gate_bist_ctrl #(.N_IN(2), .EXP(4'b0111), .SETTLE(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(start3), .pat_out(pat3), .dut_res(res3),
    .busy(busy3), .done(done3), .pass(pass3), .err_cnt(err3),
    .fail_idx(fail3), .signature(sig3)
  );

  // Gate under test: 0 NAND, 1 stuck-at-0, 2 AND, 3 stuck-at-1, 4 NOR.
  always_comb begin
    res0 = 1'b0;
    case (mode)
      0: res0 = ~&pat0;
      1: res0 = 1'b0;
      2: res0 = &pat0;
      3: res0 = 1'b1;
      4: res0 = ~|pat0;
      default: res0 = 1'b0;
    endcase
  end
  assign res3 = ~&pat3;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout expected=completion", name);
  endtask

  function automatic exp_t mk(input int err, input int fail, input int pass,
                              input int sig, input int lat);
    exp_t e;
    e.err  = err;
    e.fail = fail;
    e.pass = pass;
`ifdef GATE_BIST_SIG_EN
    e.sig  = sig;
`else
    e.sig  = 0;
`endif
    e.lat       = lat;
    e.start_cyc = 0;
    return e;
  endfunction

  function automatic int qsize(input int w);
    return (w == 0) ? sb0.size() : sb3.size();
  endfunction

  task automatic score(input string tag, input exp_t e, input logic [2:0] err,
                       input logic [1:0] fail, input logic pass, input logic [3:0] sig,
                       input logic [1:0] pat, input int lat);
    check({tag, "_err_cnt"},  err,  e.err);
    check({tag, "_fail_idx"}, fail, e.fail);
    check({tag, "_pass"},     pass, e.pass);
    check({tag, "_signature"}, sig, e.sig);
    check({tag, "_pat_hold"}, pat,  3);
    check({tag, "_latency"},  lat,  e.lat);
  endtask

  // Monitor: per-cycle pattern tracking while busy, full result check on done rise.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst) begin
      if (busy0) begin
        if (sb0.size() == 0) check("busy0_no_run", busy0, 0);
        else check("pat0_seq", pat0, (cyc - sb0[0].start_cyc) / 2);
      end
      if (done0 && !done0_prev) begin
        if (sb0.size() == 0) check("done0_no_run", done0, 0);
        else begin
          e = sb0.pop_front();
          score("s1", e, err0, fail0, pass0, sig0, pat0, cyc - e.start_cyc);
        end
      end
      if (busy3) begin
        if (sb3.size() == 0) check("busy3_no_run", busy3, 0);
        else check("pat3_seq", pat3, (cyc - sb3[0].start_cyc) / 4);
      end
      if (done3 && !done3_prev) begin
        if (sb3.size() == 0) check("done3_no_run", done3, 0);
        else begin
          e = sb3.pop_front();
          score("s3", e, err3, fail3, pass3, sig3, pat3, cyc - e.start_cyc);
        end
      end
    end
    done0_prev <= done0;
    done3_prev <= done3;
  end

  task automatic launch(input int w, input exp_t e);
    @(negedge clk);
    e.start_cyc = cyc + 1;
    if (w == 0) begin
      sb0.push_back(e);
      start0 = 1'b1;
    end else begin
      sb3.push_back(e);
      start3 = 1'b1;
    end
    @(negedge clk);
    start0 = 1'b0;
    start3 = 1'b0;
  endtask

  task automatic drain(input int w, input int budget);
    int n = 0;
    while (qsize(w) != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (qsize(w) != 0) begin
      fail_now(w == 0 ? "drain0" : "drain3");
      if (w == 0) sb0.delete(); else sb3.delete();
    end
  endtask

  task automatic check_zero0(input string tag);
    check({tag, "_pat_out"},   pat0,  0);
    check({tag, "_busy"},      busy0, 0);
    check({tag, "_done"},      done0, 0);
    check({tag, "_pass"},      pass0, 0);
    check({tag, "_err_cnt"},   err0,  0);
    check({tag, "_fail_idx"},  fail0, 0);
    check({tag, "_signature"}, sig0,  0);
  endtask

  initial begin
    exp_t e1, e2;
    int   n;
    checks = 0; failures = 0;
    rst = 1'b1; start0 = 1'b0; start3 = 1'b0; mode = 0;
    done0_prev = 1'b0; done3_prev = 1'b0;
    repeat (3) @(negedge clk);
    check_zero0("reset0");
    check("reset3_busy", busy3, 0);
    check("reset3_pat_out", pat3, 0);
    rst = 1'b0;

    // Directed gate responses against NAND expectation.
    mode = 0; launch(0, mk(0, 0, 1, 4'b1110, 8)); drain(0, 40);
    mode = 1; launch(0, mk(3, 0, 0, 4'b0000, 8)); drain(0, 40);
    mode = 2; launch(0, mk(4, 0, 0, 4'b0001, 8)); drain(0, 40);
    mode = 3; launch(0, mk(1, 3, 0, 4'b1111, 8)); drain(0, 40);
    mode = 4; launch(0, mk(2, 1, 0, 4'b1000, 8)); drain(0, 40);

    // Start pulse while busy is ignored; reset during pattern 2 aborts the run.
    mode = 1; launch(0, mk(3, 0, 0, 4'b0000, 8));
    repeat (2) @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_pre_err_cnt", err0, 2);
    check("abort_pre_pat_out", pat0, 2);
    #2 rst = 1'b1;
    #1 check_zero0("abort");
    sb0.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("idle_after_rst_busy", busy0, 0);
    check("idle_after_rst_done", done0, 0);
    mode = 0; launch(0, mk(0, 0, 1, 4'b1110, 8)); drain(0, 40);

    // Start held high through DONE: back-to-back identical runs.
    mode = 3;
    @(negedge clk);
    e1 = mk(1, 3, 0, 4'b1111, 8);
    e2 = e1;
    e1.start_cyc = cyc + 1;
    e2.start_cyc = cyc + 10;
    sb0.push_back(e1);
    sb0.push_back(e2);
    start0 = 1'b1;
    n = 0;
    while (sb0.size() > 1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (sb0.size() > 1) fail_now("held_first_run");
    @(negedge clk);
    start0 = 1'b0;
    drain(0, 40);

    // Longer settle time on the second instance.
    launch(3, mk(0, 0, 1, 4'b1110, 16)); drain(3, 80);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
